// File: rtl/hazard_forwarding_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline hazard/forwarding controller:
// forwarding-select encodings, controller FSM states and default field widths.
package mips_pkg;

    // Default widths: register index, forwarding select, stall-event counter
    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned FWD_SEL_W   = 3;
    localparam int unsigned STALL_CNT_W = 16;

    // ALU operand mux selects
    localparam logic [FWD_SEL_W-1:0] FWD_REG   = 3'b000;  // register file value
    localparam logic [FWD_SEL_W-1:0] FWD_EXMEM = 3'b001;  // EX/MEM pipeline register
    localparam logic [FWD_SEL_W-1:0] FWD_MEMWB = 3'b010;  // MEM/WB pipeline register

    // Debug control FSM
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/hazard_forwarding_ctrl_if.sv
// ID-stage request / control-response bundle between the pipeline datapath
// (master) and the hazard/forwarding controller (slave).
interface hazard_forwarding_ctrl_if
    import mips_pkg::*;
#(
    parameter int unsigned NBITS_REG     = REG_IDX_W,
    parameter int unsigned CORTOCIRCUITO = FWD_SEL_W,
    parameter int unsigned NBITS_CNT     = STALL_CNT_W
);

    logic [NBITS_REG-1:0]     i_id_rs;
    logic [NBITS_REG-1:0]     i_id_rt;
    logic                     i_id_use_rs;
    logic                     i_id_use_rt;
    logic [NBITS_REG-1:0]     i_id_rd;
    logic                     i_id_regwrite;
    logic                     i_id_memread;
    logic                     i_flush;
    logic                     i_halt;
    logic                     i_step;
    logic [CORTOCIRCUITO-1:0] o_corto_circuito_rega;
    logic [CORTOCIRCUITO-1:0] o_corto_circuito_regb;
    logic                     o_stall;
    logic                     o_bubble;
    logic                     o_halted;
    logic [NBITS_CNT-1:0]     o_stall_count;

    modport master (
        output i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_rd,
               i_id_regwrite, i_id_memread, i_flush, i_halt, i_step,
        input  o_corto_circuito_rega, o_corto_circuito_regb,
               o_stall, o_bubble, o_halted, o_stall_count
    );

    modport slave (
        input  i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_rd,
               i_id_regwrite, i_id_memread, i_flush, i_halt, i_step,
        output o_corto_circuito_rega, o_corto_circuito_regb,
               o_stall, o_bubble, o_halted, o_stall_count
    );

endinterface

// File: rtl/hazard_forwarding_ctrl_fwd_select.sv
// Forwarding priority for one ALU operand: the nearest in-flight writer of the
// source register wins; register 0 is never forwarded.
module fwd_select
    import mips_pkg::*;
#(
    parameter int unsigned NBITS_REG     = REG_IDX_W,
    parameter int unsigned CORTOCIRCUITO = FWD_SEL_W
)(
    input  logic                     ex_valid,
    input  logic                     ex_regwrite,
    input  logic [NBITS_REG-1:0]     ex_rd,
    input  logic                     mem_valid,
    input  logic                     mem_regwrite,
    input  logic [NBITS_REG-1:0]     mem_rd,
    input  logic [NBITS_REG-1:0]     src,
    output logic [CORTOCIRCUITO-1:0] sel
);

    logic ex_hit;
    logic mem_hit;

    // Writer match against EX and MEM, EX taking priority
    always_comb begin
        ex_hit  = ex_valid  & ex_regwrite  & (ex_rd  != '0) & (ex_rd  == src);
        mem_hit = mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == src);
        sel     = CORTOCIRCUITO'(FWD_REG);
        if (ex_hit) begin
            sel = CORTOCIRCUITO'(FWD_EXMEM);
        end else if (mem_hit) begin
            sel = CORTOCIRCUITO'(FWD_MEMWB);
        end
    end

endmodule

// File: rtl/hazard_forwarding_ctrl.sv
// Forwarding / load-use hazard controller for the 5-stage MIPS pipeline with
// branch flush and debug halt / single-step.
module hazard_forwarding_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned NBITS_REG     = REG_IDX_W,
    parameter int unsigned CORTOCIRCUITO = FWD_SEL_W,
    parameter int unsigned NBITS_CNT     = STALL_CNT_W
)(
    input  logic                    i_clock,
    input  logic                    i_reset,
    hazard_forwarding_ctrl_if.slave bus
);

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic [NBITS_REG-1:0] rd;
    } writer_t;

    typedef struct packed {
        writer_t w;
        logic    memread;
    } ex_entry_t;

    // Only EX and MEM are consulted for forwarding; an instruction in WB has
    // already written the register file by the time ID reads it, so the WB
    // slot and the source indices carry no state anything depends on.
    ex_entry_t                sb_ex;
    writer_t                  sb_mem;
    ex_entry_t                id_entry;

    ctrl_state_t              state;
    ctrl_state_t              state_nxt;

    logic                     hazard;
    logic                     advance;
    logic                     squash;
    logic                     stall;
    logic                     bubble;
    logic                     ld_stall;

    logic [CORTOCIRCUITO-1:0] sel_a_nxt;
    logic [CORTOCIRCUITO-1:0] sel_b_nxt;
    logic [CORTOCIRCUITO-1:0] sel_a_q;
    logic [CORTOCIRCUITO-1:0] sel_b_q;
    logic [NBITS_CNT-1:0]     cnt_q;

    fwd_select #(
        .NBITS_REG     (NBITS_REG),
        .CORTOCIRCUITO (CORTOCIRCUITO)
    ) u_fwd_a (
        .ex_valid     (sb_ex.w.valid),
        .ex_regwrite  (sb_ex.w.regwrite),
        .ex_rd        (sb_ex.w.rd),
        .mem_valid    (sb_mem.valid),
        .mem_regwrite (sb_mem.regwrite),
        .mem_rd       (sb_mem.rd),
        .src          (bus.i_id_rs),
        .sel          (sel_a_nxt)
    );

    fwd_select #(
        .NBITS_REG     (NBITS_REG),
        .CORTOCIRCUITO (CORTOCIRCUITO)
    ) u_fwd_b (
        .ex_valid     (sb_ex.w.valid),
        .ex_regwrite  (sb_ex.w.regwrite),
        .ex_rd        (sb_ex.w.rd),
        .mem_valid    (sb_mem.valid),
        .mem_regwrite (sb_mem.regwrite),
        .mem_rd       (sb_mem.rd),
        .src          (bus.i_id_rt),
        .sel          (sel_b_nxt)
    );

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        hazard = sb_ex.w.valid & sb_ex.memread & (sb_ex.w.rd != '0) &
                 ((bus.i_id_use_rs & (sb_ex.w.rd == bus.i_id_rs)) |
                  (bus.i_id_use_rt & (sb_ex.w.rd == bus.i_id_rt)));
        id_entry.w.valid    = 1'b1;
        id_entry.w.regwrite = bus.i_id_regwrite;
        id_entry.w.rd       = bus.i_id_rd;
        id_entry.memread    = bus.i_id_memread;
    end

    // Debug FSM state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Debug FSM next state: halt request is a level
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (bus.i_halt)  state_nxt = HALT;
            HALT:    if (!bus.i_halt) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Debug FSM outputs; a step cycle in HALT follows the full RUN rules
    always_comb begin
        advance  = (state == RUN) | bus.i_step;
        squash   = hazard | bus.i_flush;
        stall    = advance ? (hazard & ~bus.i_flush) : 1'b1;
        bubble   = advance & squash;
        ld_stall = advance & hazard & ~bus.i_flush;
    end

    // Scoreboard shift and registered forwarding selects
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sb_ex   <= '0;
            sb_mem  <= '0;
            sel_a_q <= CORTOCIRCUITO'(FWD_REG);
            sel_b_q <= CORTOCIRCUITO'(FWD_REG);
        end else if (advance) begin
            sb_mem  <= sb_ex.w;
            sb_ex   <= squash ? '0 : id_entry;
            sel_a_q <= squash ? CORTOCIRCUITO'(FWD_REG) : sel_a_nxt;
            sel_b_q <= squash ? CORTOCIRCUITO'(FWD_REG) : sel_b_nxt;
        end
    end

    // Saturating load-use stall counter
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (ld_stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Drive the response side of the bus
    always_comb begin
        bus.o_corto_circuito_rega = sel_a_q;
        bus.o_corto_circuito_regb = sel_b_q;
        bus.o_stall               = stall;
        bus.o_bubble              = bubble;
        bus.o_halted              = (state == HALT);
        bus.o_stall_count         = cnt_q;
    end

endmodule
